// File: rtl/game_state_controller_pkg.sv
// Shared constants for the Frogger game: state codes, game limits and frog home position.
package game_state_controller_pkg;

   localparam logic [2:0] c_ST_IDLE      = 3'd0;
   localparam logic [2:0] c_ST_PLAY      = 3'd1;
   localparam logic [2:0] c_ST_DEATH     = 3'd2;
   localparam logic [2:0] c_ST_LEVEL_UP  = 3'd3;
   localparam logic [2:0] c_ST_GAME_OVER = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE      = c_ST_IDLE,
      S_PLAY      = c_ST_PLAY,
      S_DEATH     = c_ST_DEATH,
      S_LEVEL_UP  = c_ST_LEVEL_UP,
      S_GAME_OVER = c_ST_GAME_OVER
   } state_t;

   localparam int c_START_LIVES    = 3;
   localparam int c_MAX_SCORE      = 99;
   localparam int c_MAX_LEVEL      = 7;
   localparam int c_DEATH_FRAMES   = 60;
   localparam int c_LEVELUP_FRAMES = 30;

   // Frog home position, consumed by frog movement on o_Frog_Reset.
   localparam int c_X_BASE_POSITION = 320;
   localparam int c_Y_BASE_POSITION = 448;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/game_state_controller_frame_timer.sv
// Tick-gated frame counter: counts frame ticks from 0 and flags the tick that lands on terminal.
module frame_timer #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             tick,
   input  logic [WIDTH-1:0] terminal,
   output logic             done
);

   logic [WIDTH-1:0] count;

   assign done = tick && (count == terminal);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clear || done)
         count <= '0;
      else if (tick)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/game_state_controller.sv
// Frogger top-level sequencer: game state, lives, score, level, frog movement enable and respawn.
//
// state      | meaning
// IDLE       | title screen, waiting for a start edge
// PLAY       | frog moves; collisions and goals are acted on
// DEATH      | frog frozen for DEATH_FRAMES frames, then respawn
// LEVEL_UP   | frog frozen for LEVELUP_FRAMES frames, then respawn
// GAME_OVER  | score/level held for display until a start edge
module game_state_controller
   import game_state_controller_pkg::*;
#(
   parameter int START_LIVES    = c_START_LIVES,
   parameter int MAX_SCORE      = c_MAX_SCORE,
   parameter int MAX_LEVEL      = c_MAX_LEVEL,
   parameter int DEATH_FRAMES   = c_DEATH_FRAMES,
   parameter int LEVELUP_FRAMES = c_LEVELUP_FRAMES
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_Frame_Tick,
   input  logic       i_Start,
   input  logic       i_Collision,
   input  logic       i_Goal,
   output logic       o_Move_En,
   output logic       o_Frog_Reset,
   output logic [2:0] o_State,
   output logic [2:0] o_Lives,
   output logic [6:0] o_Score,
   output logic [2:0] o_Level,
   output logic       o_Game_Over
);

   localparam int CNT_W = $clog2(max_int(DEATH_FRAMES, LEVELUP_FRAMES));

   state_t     state, state_nxt;
   logic       start_q;
   logic       start_edge;
   logic [2:0] lives, lives_nxt;
   logic [6:0] score, score_nxt;
   logic [2:0] level, level_nxt;
   logic       frog_reset_q;
   logic       timer_clear;
   logic       timer_done;
   logic [CNT_W-1:0] timer_terminal;

   assign start_edge     = i_Start && !start_q;
   assign timer_clear    = !((state == S_DEATH) || (state == S_LEVEL_UP));
   assign timer_terminal = (state == S_DEATH) ? CNT_W'(DEATH_FRAMES - 1)
                                              : CNT_W'(LEVELUP_FRAMES - 1);

   frame_timer #(
      .WIDTH (CNT_W)
   ) u_frame_timer (
      .clk      (i_Clk),
      .rst_n    (i_Rst_L),
      .clear    (timer_clear),
      .tick     (i_Frame_Tick),
      .terminal (timer_terminal),
      .done     (timer_done)
   );

   always_comb begin
      state_nxt = state;
      lives_nxt = lives;
      score_nxt = score;
      level_nxt = level;
      case (state)
         S_IDLE: begin
            if (start_edge) begin
               lives_nxt = 3'(START_LIVES);
               score_nxt = '0;
               level_nxt = 3'd1;
               state_nxt = S_PLAY;
            end
         end
         S_PLAY: begin
            // Collision has priority over a simultaneous goal.
            if (i_Collision) begin
               if (lives != '0)
                  lives_nxt = lives - 3'd1;
               state_nxt = (lives <= 3'd1) ? S_GAME_OVER : S_DEATH;
            end else if (i_Goal) begin
               score_nxt = (score < 7'(MAX_SCORE)) ? score + 7'd1 : 7'(MAX_SCORE);
               level_nxt = (level < 3'(MAX_LEVEL)) ? level + 3'd1 : 3'(MAX_LEVEL);
               state_nxt = S_LEVEL_UP;
            end
         end
         S_DEATH, S_LEVEL_UP: begin
            if (timer_done)
               state_nxt = S_PLAY;
         end
         S_GAME_OVER: begin
            if (start_edge)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state        <= S_IDLE;
         start_q      <= 1'b0;
         lives        <= '0;
         score        <= '0;
         level        <= 3'd1;
         frog_reset_q <= 1'b0;
      end else begin
         state        <= state_nxt;
         start_q      <= i_Start;
         lives        <= lives_nxt;
         score        <= score_nxt;
         level        <= level_nxt;
         frog_reset_q <= (state_nxt == S_PLAY) && (state != S_PLAY);
      end
   end

   assign o_Move_En    = (state == S_PLAY);
   assign o_Game_Over  = (state == S_GAME_OVER);
   assign o_Frog_Reset = frog_reset_q;
   assign o_State      = state;
   assign o_Lives      = lives;
   assign o_Score      = score;
   assign o_Level      = level;

endmodule

// File: tb/tb_game_state_controller.sv
// Self-checking bench for game_state_controller: game-rule model compared every cycle plus directed literals.
module tb_game_state_controller;

   logic       i_Clk = 1'b0;
   logic       i_Rst_L = 1'b0;
   logic       i_Frame_Tick = 1'b0;
   logic       i_Start = 1'b0;
   logic       i_Collision = 1'b0;
   logic       i_Goal = 1'b0;
   logic       o_Move_En, o_Frog_Reset, o_Game_Over;
   logic [2:0] o_State, o_Lives, o_Level;
   logic [6:0] o_Score;

   int checks = 0;
   int failures = 0;
   int fr_count = 0;

   game_state_controller dut (
      .i_Clk        (i_Clk),
      .i_Rst_L      (i_Rst_L),
      .i_Frame_Tick (i_Frame_Tick),
      .i_Start      (i_Start),
      .i_Collision  (i_Collision),
      .i_Goal       (i_Goal),
      .o_Move_En    (o_Move_En),
      .o_Frog_Reset (o_Frog_Reset),
      .o_State      (o_State),
      .o_Lives      (o_Lives),
      .o_Score      (o_Score),
      .o_Level      (o_Level),
      .o_Game_Over  (o_Game_Over)
   );

   always #5 i_Clk = ~i_Clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Game-rule model: state as a plain int, hold time as ticks remaining.
   int m_state = 0, m_lives = 0, m_score = 0, m_level = 1, m_left = 0;
   bit m_fr = 0, m_prev_start = 0;

   always @(posedge i_Clk or negedge i_Rst_L) begin : model
      int st, lv, sc, le, lf;
      bit fr, edge_s;
      if (!i_Rst_L) begin
         m_state <= 0; m_lives <= 0; m_score <= 0; m_level <= 1;
         m_left <= 0; m_fr <= 0; m_prev_start <= 0;
      end else begin
         st = m_state; lv = m_lives; sc = m_score; le = m_level; lf = m_left; fr = 0;
         edge_s = i_Start && !m_prev_start;
         if (m_state == 0 && edge_s) begin
            lv = 3; sc = 0; le = 1; st = 1; fr = 1;
         end else if (m_state == 1 && i_Collision) begin
            lv = m_lives - 1;
            if (lv == 0) st = 4;
            else begin st = 2; lf = 60; end
         end else if (m_state == 1 && i_Goal) begin
            sc = (m_score + 1 > 99) ? 99 : m_score + 1;
            le = (m_level + 1 > 7) ? 7 : m_level + 1;
            st = 3; lf = 30;
         end else if ((m_state == 2 || m_state == 3) && i_Frame_Tick) begin
            lf = m_left - 1;
            if (lf == 0) begin st = 1; fr = 1; end
         end else if (m_state == 4 && edge_s) begin
            st = 0;
         end
         m_state <= st; m_lives <= lv; m_score <= sc; m_level <= le;
         m_left <= lf; m_fr <= fr; m_prev_start <= i_Start;
      end
   end

   always @(negedge i_Clk) begin
      chk("state", int'(o_State), m_state);
      chk("lives", int'(o_Lives), m_lives);
      chk("score", int'(o_Score), m_score);
      chk("level", int'(o_Level), m_level);
      chk("move_en", int'(o_Move_En), int'(m_state == 1));
      chk("game_over", int'(o_Game_Over), int'(m_state == 4));
      chk("frog_reset", int'(o_Frog_Reset), int'(m_fr));
      if (o_Frog_Reset) fr_count++;
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge i_Clk);
         #2;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         i_Frame_Tick = 1'b1; step();
         i_Frame_Tick = 1'b0; step();
      end
   endtask

   task automatic pulse_start();
      i_Start = 1'b1; step();
      i_Start = 1'b0; step();
   endtask

   task automatic pulse_collision();
      i_Collision = 1'b1; step();
      i_Collision = 1'b0; step();
   endtask

   task automatic do_goal();
      i_Goal = 1'b1; step();
      i_Goal = 1'b0; step();
      tick(30);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      step(3);
      chk("rst_state", int'(o_State), 0);
      chk("rst_level", int'(o_Level), 1);
      i_Rst_L = 1'b1;
      step(10);
      chk("idle_state", int'(o_State), 0);
      chk("idle_lives", int'(o_Lives), 0);
      chk("idle_score", int'(o_Score), 0);
      chk("idle_level", int'(o_Level), 1);
      chk("idle_move_en", int'(o_Move_En), 0);
      chk("idle_fr_count", fr_count, 0);

      i_Start = 1'b1; step(100); i_Start = 1'b0; step();
      chk("start_fr_count", fr_count, 1);
      chk("start_state", int'(o_State), 1);
      chk("start_lives", int'(o_Lives), 3);
      chk("start_move_en", int'(o_Move_En), 1);

      pulse_collision();
      chk("death_lives", int'(o_Lives), 2);
      chk("death_state", int'(o_State), 2);
      pulse_collision();
      chk("death_ignored_lives", int'(o_Lives), 2);
      tick(59);
      chk("death_59_state", int'(o_State), 2);
      chk("death_59_fr_count", fr_count, 1);
      tick(1);
      chk("death_60_state", int'(o_State), 1);
      chk("death_60_fr_count", fr_count, 2);

      pulse_collision(); tick(60);
      chk("second_lives", int'(o_Lives), 1);
      pulse_collision();
      chk("go_lives", int'(o_Lives), 0);
      chk("go_state", int'(o_State), 4);
      chk("go_flag", int'(o_Game_Over), 1);
      pulse_start();
      chk("go_to_idle", int'(o_State), 0);
      pulse_start();
      chk("restart_state", int'(o_State), 1);
      chk("restart_lives", int'(o_Lives), 3);
      chk("restart_score", int'(o_Score), 0);

      i_Goal = 1'b1; i_Collision = 1'b1; step();
      i_Goal = 1'b0; i_Collision = 1'b0; step();
      chk("both_lives", int'(o_Lives), 2);
      chk("both_score", int'(o_Score), 0);
      chk("both_state", int'(o_State), 2);
      tick(60);

      repeat (5) do_goal();
      chk("goal5_score", int'(o_Score), 5);
      chk("goal5_level", int'(o_Level), 6);
      do_goal();
      chk("goal6_level", int'(o_Level), 7);
      do_goal();
      chk("goal7_level", int'(o_Level), 7);
      repeat (91) do_goal();
      chk("goal98_score", int'(o_Score), 98);
      do_goal();
      chk("goal99_score", int'(o_Score), 99);
      do_goal();
      chk("goal100_score", int'(o_Score), 99);
      chk("goal100_level", int'(o_Level), 7);

      i_Goal = 1'b1; step(); i_Goal = 1'b0; step();
      tick(5);
      chk("lu_state", int'(o_State), 3);
      i_Rst_L = 1'b0;
      #1;
      chk("mid_rst_state", int'(o_State), 0);
      chk("mid_rst_lives", int'(o_Lives), 0);
      chk("mid_rst_score", int'(o_Score), 0);
      chk("mid_rst_level", int'(o_Level), 1);
      chk("mid_rst_move_en", int'(o_Move_En), 0);
      chk("mid_rst_frog_reset", int'(o_Frog_Reset), 0);
      chk("mid_rst_game_over", int'(o_Game_Over), 0);
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/game_state_controller.md
Name: game_state_controller

Overview:
Top-level sequencer for the Frogger game. It owns the game state (title, play, death, level-up, game over), lives, score and level. It enables or freezes frog movement and issues frog respawn pulses. It sits between the debounced switches, frog movement, collision/goal detection and the sprite/VGA display path, and paces all timing on a one-pulse-per-frame tick.

Parameters:
- START_LIVES, 3, lives loaded at game start (1..7).
- MAX_SCORE, 99, score saturation value (fits 7 bits).
- MAX_LEVEL, 7, level saturation value (fits 3 bits).
- DEATH_FRAMES, 60, frames held in DEATH before respawn.
- LEVELUP_FRAMES, 30, frames held in LEVEL_UP before respawn.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_Frame_Tick  in  1  single-cycle pulse, once per video frame, at start of vertical blanking.
- i_Start  in  1  debounced level from a switch; the block detects rising edges internally.
- i_Collision  in  1  frog overlaps a hazard; level, sampled every cycle.
- i_Goal  in  1  frog reached the goal row; level, sampled every cycle.
- o_Move_En  out  1  frog movement allowed.
- o_Frog_Reset  out  1  one-cycle pulse; frog returns to c_X_BASE_POSITION / c_Y_BASE_POSITION.
- o_State  out  3  encoded current state, for display.
- o_Lives  out  3  remaining lives.
- o_Score  out  7  goals reached this game.
- o_Level  out  3  current level, 1..MAX_LEVEL; also the obstacle speed select.
- o_Game_Over  out  1  high while in GAME_OVER.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; o_Lives = 0; o_Score = 0; o_Level = 1.
  - o_Move_En = 0; o_Frog_Reset = 0; o_Game_Over = 0; frame counter = 0; start-edge register = 0.
- States and encoding: IDLE = 0, PLAY = 1, DEATH = 2, LEVEL_UP = 3, GAME_OVER = 4. Codes 5–7 are illegal and recover to IDLE on the next clock.
- Start edge: i_Start = 1 while its previous-cycle sample = 0. Holding the switch never retriggers.
- IDLE:
  - On a start edge: lives = START_LIVES, score = 0, level = 1, pulse o_Frog_Reset, go to PLAY.
  - All registers update on the same clock edge.
- PLAY:
  - o_Move_En = 1, combinational from state.
  - i_Collision = 1: lives - 1, then:
    - lives now 0 → GAME_OVER.
    - otherwise → DEATH, frame counter cleared.
  - i_Goal = 1 with i_Collision = 0:
    - score + 1, saturating at MAX_SCORE.
    - level + 1, saturating at MAX_LEVEL.
    - go to LEVEL_UP, frame counter cleared.
  - Collision and goal in the same cycle: collision wins; score is unchanged.
  - Events are acted on only in PLAY. In every other state they are ignored.
- DEATH / LEVEL_UP:
  - o_Move_En = 0.
  - Counter increments only on i_Frame_Tick.
  - When counter = DEATH_FRAMES-1 (or LEVELUP_FRAMES-1) and a tick arrives: pulse o_Frog_Reset, go to PLAY.
  - Latency from the state entry edge is exactly N ticks.
- GAME_OVER:
  - o_Game_Over = 1; score and level are held for display.
  - On a start edge: go to IDLE, with no counter reload.
  - A second start edge is needed to begin a new game.
- o_Frog_Reset is registered. It is high for the single cycle after the transition edge into PLAY, and never two cycles in a row.
- Lives never underflow: decrement happens only when lives ≥ 1. Lives = 0 in PLAY is impossible by construction.
- Counter width: clog2 of max(DEATH_FRAMES, LEVELUP_FRAMES).
- Reset asserted mid-DEATH, mid-LEVEL_UP or mid-PLAY returns immediately to the reset values listed above.

Decomposition:
- Shared constants file gains:
  - state codes c_ST_IDLE .. c_ST_GAME_OVER.
  - c_START_LIVES, c_MAX_SCORE, c_MAX_LEVEL.
  - Existing c_X_BASE_POSITION / c_Y_BASE_POSITION stay there and are used by frog movement on o_Frog_Reset.
- One sub-module, frame_timer: tick-gated counter with clear and terminal-count output, parameterised width. It is reused for both the DEATH and LEVEL_UP holds.
- The FSM, score, lives and level live in the top module.

Test Plan:
- Reset, then 10 cycles idle → o_State = 0, o_Lives = 0, o_Score = 0, o_Level = 1, o_Move_En = 0, o_Frog_Reset never high.
- i_Start held high for 100 cycles → exactly one o_Frog_Reset pulse; o_State = 1, o_Lives = 3, o_Move_En = 1.
- In PLAY, i_Collision for 1 cycle → o_Lives = 2, o_State = 2. After 60 i_Frame_Tick pulses (not 59) → one o_Frog_Reset pulse, o_State = 1. A collision pulse during DEATH is ignored.
- Three collisions separated by DEATH holds → o_Lives = 0, o_State = 4, o_Game_Over = 1. Start edge → IDLE; second start edge → PLAY with o_Lives = 3, o_Score = 0.
- i_Goal and i_Collision asserted in the same cycle → o_Lives decrements, o_Score unchanged, o_State = 2.
- Goals forced with o_Score = 98 and o_Level = 6 → after two LEVEL_UP cycles, o_Score = 99 then 99 and o_Level = 7 then 7. i_Rst_L pulsed low mid-LEVEL_UP → all outputs at reset values immediately, before the next clock.
